// File: rtl/pong_frame_engine.sv
// Pong frame engine: pixel stage that sits directly after the VGA sync/counter block.
// Holds the game state (ball, two paddles, scores, serve/play/point phase), advances it
// once per frame on the tick at the end of the visible area, and renders registered
// 8-bit RGB with one cycle of latency.
//
// Ports:
//   VGA_CLK                 pixel clock shared with the sync block
//   Reset                   synchronous, active-high; wins over a coincident tick
//   CounterX / CounterY     raster position from the sync block
//   VGA_AREA                visible-area flag; RGB is forced to black outside it
//   BtnUpL/BtnDnL           left paddle controls, level-sensitive
//   BtnUpR/BtnDnR           right paddle controls, level-sensitive
//   Serve                   launches the ball from the serve phase, level-sensitive
//   VGA_R / VGA_G / VGA_B   registered pixel colour
//   ScoreL / ScoreR         player scores, saturating at 15
//   FrameTick               one-cycle pulse in the cycle after each game-state update
module pong_frame_engine #(
    parameter int unsigned SCREEN_W     = 640,
    parameter int unsigned SCREEN_H     = 480,
    parameter int unsigned BALL_SIZE    = 8,
    parameter int unsigned BALL_SPEED   = 2,
    parameter int unsigned PADDLE_W     = 8,
    parameter int unsigned PADDLE_H     = 64,
    parameter int unsigned PADDLE_STEP  = 4,
    parameter int unsigned LEFT_PAD_X   = 16,
    parameter int unsigned RIGHT_PAD_X  = 616,
    parameter int unsigned POINT_FRAMES = 60
) (
    input  logic       VGA_CLK,
    input  logic       Reset,
    input  logic [9:0] CounterX,
    input  logic [8:0] CounterY,
    input  logic       VGA_AREA,
    input  logic       BtnUpL,
    input  logic       BtnDnL,
    input  logic       BtnUpR,
    input  logic       BtnDnR,
    input  logic       Serve,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic [3:0] ScoreL,
    output logic [3:0] ScoreR,
    output logic       FrameTick
);

    typedef enum logic [1:0] {
        StServe = 2'd0,
        StPlay  = 2'd1,
        StPoint = 2'd2
    } state_e;

    localparam int unsigned CntW = (POINT_FRAMES > 1) ? $clog2(POINT_FRAMES) : 1;

    // All geometry is evaluated at 11 bits so that one step of overshoot past the
    // screen edge (or below zero before the guard) never wraps into a valid value.
    localparam logic [10:0] BallX0    = 11'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [10:0] BallY0    = 11'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [10:0] PadY0     = 11'((SCREEN_H - PADDLE_H) / 2);
    localparam logic [10:0] PadYMax   = 11'(SCREEN_H - PADDLE_H);
    localparam logic [10:0] BallYMax  = 11'(SCREEN_H - BALL_SIZE);
    localparam logic [10:0] ScrW      = 11'(SCREEN_W);
    localparam logic [10:0] ScrH      = 11'(SCREEN_H);
    localparam logic [10:0] Size      = 11'(BALL_SIZE);
    localparam logic [10:0] Speed     = 11'(BALL_SPEED);
    localparam logic [10:0] Step      = 11'(PADDLE_STEP);
    localparam logic [10:0] PadW      = 11'(PADDLE_W);
    localparam logic [10:0] PadH      = 11'(PADDLE_H);
    localparam logic [10:0] LeftX     = 11'(LEFT_PAD_X);
    localparam logic [10:0] LeftFace  = 11'(LEFT_PAD_X + PADDLE_W);
    localparam logic [10:0] RightX    = 11'(RIGHT_PAD_X);
    localparam logic [10:0] RightStop = 11'(RIGHT_PAD_X - BALL_SIZE);
    localparam logic [10:0] NetLo     = 11'(SCREEN_W / 2 - 2);
    localparam logic [10:0] NetHi     = 11'(SCREEN_W / 2 + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(POINT_FRAMES - 1);

    state_e          state_q, state_d;
    logic [9:0]      ball_x_q, ball_x_d;
    logic [8:0]      ball_y_q, ball_y_d;
    logic [8:0]      pad_l_q, pad_l_d;
    logic [8:0]      pad_r_q, pad_r_d;
    logic            dir_x_q, dir_x_d;          // 1 = moving right
    logic            dir_y_q, dir_y_d;          // 1 = moving down
    logic            serve_dir_q, serve_dir_d;  // 1 = next serve goes right
    logic [3:0]      score_l_q, score_l_d;
    logic [3:0]      score_r_q, score_r_d;
    logic [CntW-1:0] point_cnt_q, point_cnt_d;
    logic            frame_tick_q;
    logic [23:0]     rgb_q, rgb_d;

    logic        tick;
    logic [10:0] bx, by, pl, pr, cx, cy;
    logic        overlap_l, overlap_r;
    logic        in_ball, in_pad_l, in_pad_r, in_net;

    function automatic logic [8:0] pad_move(input logic [8:0] y, input logic up,
                                            input logic dn);
        logic [10:0] y_w;
        logic [10:0] res;
        y_w = {2'b00, y};
        res = y_w;
        if (up && !dn) begin
            res = (y_w < Step) ? 11'd0 : (y_w - Step);
        end else if (dn && !up) begin
            res = ((y_w + Step) > PadYMax) ? PadYMax : (y_w + Step);
        end
        return 9'(res);
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s == 4'hF) ? s : (s + 4'd1);
    endfunction

    // The tick sits in horizontal blanking of the last visible line, so the state
    // seen by the renderer is constant across the whole visible frame.
    assign tick = (CounterX == 10'h2FF) && (CounterY == 9'(SCREEN_H - 1));

    assign bx = {1'b0, ball_x_q};
    assign by = {2'b00, ball_y_q};
    assign pl = {2'b00, pad_l_q};
    assign pr = {2'b00, pad_r_q};
    assign cx = {1'b0, CounterX};
    assign cy = {2'b00, CounterY};

    // Vertical overlap with each paddle, using the values from before this tick.
    assign overlap_l = ((by + Size) > pl) && (by < (pl + PadH));
    assign overlap_r = ((by + Size) > pr) && (by < (pr + PadH));

    always_comb begin
        state_d     = state_q;
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        pad_l_d     = pad_l_q;
        pad_r_d     = pad_r_q;
        dir_x_d     = dir_x_q;
        dir_y_d     = dir_y_q;
        serve_dir_d = serve_dir_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        point_cnt_d = point_cnt_q;

        if (tick) begin
            pad_l_d = pad_move(pad_l_q, BtnUpL, BtnDnL);
            pad_r_d = pad_move(pad_r_q, BtnUpR, BtnDnR);

            unique case (state_q)
                StServe: begin
                    ball_x_d = 10'(BallX0);
                    ball_y_d = 9'(BallY0);
                    if (Serve) begin
                        state_d = StPlay;
                        dir_x_d = serve_dir_q;
                        dir_y_d = 1'b1;
                    end
                end

                StPlay: begin
                    // Vertical: bounce off top/bottom walls, independent of X.
                    if (!dir_y_q) begin
                        if (by < Speed) begin
                            ball_y_d = '0;
                            dir_y_d  = 1'b1;
                        end else begin
                            ball_y_d = 9'(by - Speed);
                        end
                    end else begin
                        if ((by + Size + Speed) > ScrH) begin
                            ball_y_d = 9'(BallYMax);
                            dir_y_d  = 1'b0;
                        end else begin
                            ball_y_d = 9'(by + Speed);
                        end
                    end

                    // Horizontal: paddle face first, then miss, then plain motion.
                    if (!dir_x_q) begin
                        if ((bx >= LeftFace) && ((bx - Speed) < LeftFace) && overlap_l) begin
                            ball_x_d = 10'(LeftFace);
                            dir_x_d  = 1'b1;
                        end else if (bx < Speed) begin
                            score_r_d   = sat_inc(score_r_q);
                            serve_dir_d = 1'b0;
                            state_d     = StPoint;
                        end else begin
                            ball_x_d = 10'(bx - Speed);
                        end
                    end else begin
                        if (((bx + Size) <= RightX) && ((bx + Size + Speed) > RightX)
                            && overlap_r) begin
                            ball_x_d = 10'(RightStop);
                            dir_x_d  = 1'b0;
                        end else if ((bx + Size + Speed) > ScrW) begin
                            score_l_d   = sat_inc(score_l_q);
                            serve_dir_d = 1'b1;
                            state_d     = StPoint;
                        end else begin
                            ball_x_d = 10'(bx + Speed);
                        end
                    end
                end

                StPoint: begin
                    // Counter starts at 0 on entry; the tick that finds it at
                    // POINT_FRAMES-1 is the last of POINT_FRAMES ticks spent here.
                    if (point_cnt_q == CntLast) begin
                        point_cnt_d = '0;
                        ball_x_d    = 10'(BallX0);
                        ball_y_d    = 9'(BallY0);
                        state_d     = StServe;
                    end else begin
                        point_cnt_d = point_cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_d = StServe;
                end
            endcase
        end
    end

    assign in_ball  = (cx >= bx) && (cx < (bx + Size)) && (cy >= by) && (cy < (by + Size));
    assign in_pad_l = (cx >= LeftX) && (cx < (LeftX + PadW))
                      && (cy >= pl) && (cy < (pl + PadH));
    assign in_pad_r = (cx >= RightX) && (cx < (RightX + PadW))
                      && (cy >= pr) && (cy < (pr + PadH));
    assign in_net   = (cx >= NetLo) && (cx <= NetHi) && !CounterY[4];

    always_comb begin
        rgb_d = 24'h000000;
        if (VGA_AREA) begin
            if (in_ball || in_pad_l || in_pad_r) begin
                rgb_d = 24'hFFFFFF;
            end else if (in_net) begin
                rgb_d = 24'h808080;
            end
        end
    end

    always_ff @(posedge VGA_CLK) begin
        if (Reset) begin
            state_q      <= StServe;
            ball_x_q     <= 10'(BallX0);
            ball_y_q     <= 9'(BallY0);
            pad_l_q      <= 9'(PadY0);
            pad_r_q      <= 9'(PadY0);
            dir_x_q      <= 1'b1;
            dir_y_q      <= 1'b1;
            serve_dir_q  <= 1'b1;
            score_l_q    <= '0;
            score_r_q    <= '0;
            point_cnt_q  <= '0;
            frame_tick_q <= 1'b0;
            rgb_q        <= '0;
        end else begin
            state_q      <= state_d;
            ball_x_q     <= ball_x_d;
            ball_y_q     <= ball_y_d;
            pad_l_q      <= pad_l_d;
            pad_r_q      <= pad_r_d;
            dir_x_q      <= dir_x_d;
            dir_y_q      <= dir_y_d;
            serve_dir_q  <= serve_dir_d;
            score_l_q    <= score_l_d;
            score_r_q    <= score_r_d;
            point_cnt_q  <= point_cnt_d;
            frame_tick_q <= tick;
            rgb_q        <= rgb_d;
        end
    end

    assign VGA_R     = rgb_q[23:16];
    assign VGA_G     = rgb_q[15:8];
    assign VGA_B     = rgb_q[7:0];
    assign ScoreL    = score_l_q;
    assign ScoreR    = score_r_q;
    assign FrameTick = frame_tick_q;

endmodule

// File: tb/tb_pong_frame_engine.sv
// Testbench for pong_frame_engine. Drives the raster counters directly so that one
// frame costs a single tick cycle plus a few pixel probes. A game model written with
// plain integer arithmetic (signed velocities, frames-remaining hold counter) tracks
// the expected state; rendered pixels and scores are compared against it.
module tb_pong_frame_engine;

    logic       VGA_CLK = 1'b0;
    logic       Reset;
    logic [9:0] CounterX;
    logic [8:0] CounterY;
    logic       VGA_AREA;
    logic       BtnUpL, BtnDnL, BtnUpR, BtnDnR, Serve;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic [3:0] ScoreL, ScoreR;
    logic       FrameTick;

    pong_frame_engine dut (
        .VGA_CLK  (VGA_CLK),
        .Reset    (Reset),
        .CounterX (CounterX),
        .CounterY (CounterY),
        .VGA_AREA (VGA_AREA),
        .BtnUpL   (BtnUpL),
        .BtnDnL   (BtnDnL),
        .BtnUpR   (BtnUpR),
        .BtnDnR   (BtnDnR),
        .Serve    (Serve),
        .VGA_R    (VGA_R),
        .VGA_G    (VGA_G),
        .VGA_B    (VGA_B),
        .ScoreL   (ScoreL),
        .ScoreR   (ScoreR),
        .FrameTick(FrameTick)
    );

    always #5 VGA_CLK = ~VGA_CLK;

    int n_pass  = 0;
    int n_total = 0;

    // Game model: velocities are +1/-1 (right/down positive); m_hold counts the
    // frames left in the point pause, m_live says the ball has been served.
    int m_bx, m_by, m_vx, m_vy, m_sv, m_pl, m_pr, m_sl, m_sr, m_hold, m_misses_r;
    bit m_live;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_bx = 316; m_by = 236; m_vx = 1; m_vy = 1; m_sv = 1;
        m_pl = 208; m_pr = 208; m_sl = 0; m_sr = 0;
        m_hold = 0; m_live = 0; m_misses_r = 0;
    endtask

    function automatic int move_pad(input int y, input bit up, input bit dn);
        if (up && !dn) return (y - 4 < 0) ? 0 : y - 4;
        if (dn && !up) return (y + 4 > 416) ? 416 : y + 4;
        return y;
    endfunction

    task automatic model_tick(input bit ul, input bit dl, input bit ur, input bit dr,
                              input bit sv);
        int npl, npr, nx, ny;
        bit ovl, ovr;
        npl = move_pad(m_pl, ul, dl);
        npr = move_pad(m_pr, ur, dr);
        ovl = (m_by + 8 > m_pl) && (m_by < m_pl + 64);
        ovr = (m_by + 8 > m_pr) && (m_by < m_pr + 64);
        if (m_hold > 0) begin
            m_hold--;
            if (m_hold == 0) begin
                m_live = 0; m_bx = 316; m_by = 236;
            end
        end else if (!m_live) begin
            m_bx = 316; m_by = 236;
            if (sv) begin
                m_live = 1; m_vx = m_sv; m_vy = 1;
            end
        end else begin
            ny = m_by + 2 * m_vy;
            if (ny < 0) begin
                m_by = 0; m_vy = 1;
            end else if (ny + 8 > 480) begin
                m_by = 472; m_vy = -1;
            end else begin
                m_by = ny;
            end
            nx = m_bx + 2 * m_vx;
            if (m_vx < 0 && m_bx >= 24 && nx < 24 && ovl) begin
                m_bx = 24; m_vx = 1;
            end else if (m_vx > 0 && m_bx + 8 <= 616 && nx + 8 > 616 && ovr) begin
                m_bx = 608; m_vx = -1;
            end else if (m_vx < 0 && nx < 0) begin
                if (m_sr < 15) m_sr++;
                m_sv = -1; m_hold = 60;
            end else if (m_vx > 0 && nx + 8 > 640) begin
                if (m_sl < 15) m_sl++;
                m_sv = 1; m_hold = 60; m_misses_r++;
            end else begin
                m_bx = nx;
            end
        end
        m_pl = npl;
        m_pr = npr;
    endtask

    function automatic logic [31:0] model_rgb(input int x, input int y, input bit area);
        if (!area) return 32'h0;
        if (x >= m_bx && x < m_bx + 8 && y >= m_by && y < m_by + 8) return 32'hFFFFFF;
        if (x >= 16 && x < 24 && y >= m_pl && y < m_pl + 64) return 32'hFFFFFF;
        if (x >= 616 && x < 624 && y >= m_pr && y < m_pr + 64) return 32'hFFFFFF;
        if (x >= 318 && x <= 321 && (y % 32) < 16) return 32'h808080;
        return 32'h0;
    endfunction

    task automatic drive_pixel(input int x, input int y, input bit area);
        CounterX = 10'(x);
        CounterY = 9'(y);
        VGA_AREA = area;
        @(posedge VGA_CLK);
        #1;
    endtask

    task automatic probe(input string tag, input int x, input int y, input bit area);
        int xx, yy;
        xx = (x < 0) ? 0 : ((x > 767) ? 767 : x);
        yy = (y < 0) ? 0 : ((y > 511) ? 511 : y);
        if (xx == 767 && yy == 479) yy = 478;
        drive_pixel(xx, yy, area);
        check(tag, {8'h00, VGA_R, VGA_G, VGA_B}, model_rgb(xx, yy, area));
        check("frametick_lo", {31'd0, FrameTick}, 32'd0);
    endtask

    task automatic probe_const(input string tag, input int x, input int y,
                               input logic [31:0] exp);
        drive_pixel(x, y, 1'b1);
        check(tag, {8'h00, VGA_R, VGA_G, VGA_B}, exp);
    endtask

    task automatic probe_set();
        probe("ball_tl", m_bx, m_by, 1'b1);
        probe("ball_br", m_bx + 7, m_by + 7, 1'b1);
        probe("ball_right_out", m_bx + 8, m_by, 1'b1);
        probe("ball_left_out", m_bx - 1, m_by + 3, 1'b1);
        probe("ball_below_out", m_bx + 3, m_by + 8, 1'b1);
        probe("ball_no_area", m_bx, m_by, 1'b0);
        probe("padl_top", 16 + int'($urandom_range(0, 7)), m_pl, 1'b1);
        probe("padl_above", 20, m_pl - 1, 1'b1);
        probe("padr_bottom", 623, m_pr + 63, 1'b1);
        probe("padr_below", 620, m_pr + 64, 1'b1);
        probe("random_px", int'($urandom_range(0, 767)), int'($urandom_range(0, 511)),
              ($urandom_range(0, 3) != 0));
    endtask

    task automatic do_tick(input bit ul, input bit dl, input bit ur, input bit dr,
                           input bit sv, input bit do_probe);
        CounterX = 10'h2FF;
        CounterY = 9'd479;
        VGA_AREA = 1'b0;
        BtnUpL = ul; BtnDnL = dl; BtnUpR = ur; BtnDnR = dr; Serve = sv;
        @(posedge VGA_CLK);
        #1;
        model_tick(ul, dl, ur, dr, sv);
        check("frametick_hi", {31'd0, FrameTick}, 32'd1);
        check("score_l", {28'd0, ScoreL}, 32'(m_sl));
        check("score_r", {28'd0, ScoreR}, 32'(m_sr));
        if (do_probe) probe_set();
    endtask

    task automatic do_reset(input bit at_tick, input int cycles);
        Reset = 1'b1;
        BtnUpL = 0; BtnDnL = 0; BtnUpR = 0; BtnDnR = 0; Serve = 0;
        CounterX = at_tick ? 10'h2FF : 10'd0;
        CounterY = at_tick ? 9'd479 : 9'd0;
        VGA_AREA = 1'b1;
        repeat (cycles) begin
            @(posedge VGA_CLK);
            #1;
        end
        Reset = 1'b0;
        model_reset();
        check("rst_frametick", {31'd0, FrameTick}, 32'd0);
        check("rst_rgb", {8'h00, VGA_R, VGA_G, VGA_B}, 32'd0);
        check("rst_score_l", {28'd0, ScoreL}, 32'd0);
        check("rst_score_r", {28'd0, ScoreR}, 32'd0);
    endtask

    // {up, down} that steers a paddle towards the ball centre.
    function automatic bit [1:0] track(input int pad, input int ball_y);
        if (pad + 32 > ball_y + 6) return 2'b10;
        if (pad + 32 < ball_y + 2) return 2'b01;
        return 2'b00;
    endfunction

    initial begin
        bit [1:0] tl, tr;

        // Reset and idle frames: ball parked at centre, net pattern visible.
        do_reset(1'b0, 2);
        repeat (3) do_tick(0, 0, 0, 0, 0, 1);
        probe_const("centre_ball", 316, 236, 32'hFFFFFF);
        probe_const("centre_ball_br", 323, 243, 32'hFFFFFF);
        probe_const("centre_right_out", 324, 236, 32'h0);
        probe_const("net_on", 319, 0, 32'h808080);
        probe_const("net_gap", 319, 16, 32'h0);

        // Serve then ten frames of play.
        do_tick(0, 0, 0, 0, 1, 1);
        repeat (10) do_tick(0, 0, 0, 0, 0, 1);
        probe_const("play10_ball", 336, 256, 32'hFFFFFF);
        probe_const("play10_left_out", 335, 256, 32'h0);
        probe_const("play10_ball_br", 343, 263, 32'hFFFFFF);
        probe_const("play10_right_out", 344, 263, 32'h0);

        // Left paddle clamps at the top; right paddle ignores both buttons together.
        repeat (60) do_tick(1, 0, 1, 1, 0, 1);
        probe_const("padl_at_top", 16, 0, 32'hFFFFFF);
        probe_const("padl_bottom_row", 23, 63, 32'hFFFFFF);
        probe_const("padl_below", 16, 64, 32'h0);
        probe_const("padr_held_top", 616, 208, 32'hFFFFFF);
        probe_const("padr_held_bot", 623, 271, 32'hFFFFFF);
        probe_const("padr_held_above", 616, 207, 32'h0);
        probe_const("padr_held_below", 616, 272, 32'h0);

        // Long rally with tracking paddles, occasional random buttons and serves.
        for (int i = 0; i < 1200; i++) begin
            tl = track(m_pl, m_by);
            tr = track(m_pr, m_by);
            if ($urandom_range(0, 7) == 0) tl = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) tr = 2'($urandom_range(0, 3));
            do_tick(tl[1], tl[0], tr[1], tr[0], 1'($urandom_range(0, 1)), 1);
        end

        // Reset coincident with a tick: reset values win.
        do_reset(1'b1, 1);
        probe_const("post_reset_ball", 316, 236, 32'hFFFFFF);
        probe_const("post_reset_padl", 16, 208, 32'hFFFFFF);

        // Right paddle returns the ball, left paddle parked low: left miss.
        for (int i = 0; i < 1500 && m_sr == 0; i++) begin
            tr = track(m_pr, m_by);
            do_tick(0, 1, tr[1], tr[0], 1, 1);
        end
        check("left_miss_score_r", {28'd0, ScoreR}, 32'd1);
        repeat (59) do_tick(0, 0, 0, 0, 0, 1);
        do_tick(0, 0, 0, 0, 0, 1);
        probe_const("point_recentre", 316, 236, 32'hFFFFFF);
        do_tick(0, 0, 0, 0, 1, 1);
        do_tick(0, 0, 0, 0, 0, 1);
        probe_const("serve_left_ball", 314, 238, 32'hFFFFFF);
        probe_const("serve_left_out", 322, 238, 32'h0);

        // Repeated right misses: ScoreL saturates at 15.
        do_reset(1'b0, 1);
        for (int i = 0; i < 8000 && m_misses_r < 16; i++) begin
            do_tick(0, 0, 1, 0, 1, (i % 16) == 0);
        end
        check("score_l_saturated", {28'd0, ScoreL}, 32'd15);
        check("score_r_after_sat", {28'd0, ScoreR}, 32'd0);
        probe_set();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
